// File: rtl/adder_pkg.sv
// adder_pkg: FSM state encoding and CONTROL bit positions shared across the adder peripheral
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_SUB    = 2;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: register-side bundle between the ICB slave and the adder sequencer
interface adder_seq_ctrl_if #(parameter int DATA_W = 32);

    logic [DATA_W-1:0] augend;
    logic [DATA_W-1:0] addend;
    logic [31:0]       control;
    logic [DATA_W-1:0] sum;
    logic              overflow;
    logic              busy;
    logic              done;

    modport master (output augend, addend, control, input sum, overflow, busy, done);
    modport slave  (input augend, addend, control, output sum, overflow, busy, done);

endinterface

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit adder slice with carry in and carry out
module adder_chunk #(parameter int W = 8) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-cycle chunked add/subtract sequencer with sticky completion status
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    adder_seq_ctrl_if.slave bus
);

    localparam int N     = DATA_W / CHUNK_W;
    localparam int CNT_W = N > 1 ? $clog2(N) : 1;
    localparam int MSB   = DATA_W - 1;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d, sgn_q, sgn_d, sub_q, sub_d;
    logic               ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
    logic               start_q;
    logic               rise;
    logic [CHUNK_W-1:0] chunk_s;
    logic               chunk_c;
    logic               unused_ctrl;

    assign unused_ctrl = ^bus.control[31:3];
    assign rise        = bus.control[CTRL_START] & ~start_q;

    adder_chunk #(.W(CHUNK_W)) u_chunk (
        .a_i(a_q[cnt_q*CHUNK_W +: CHUNK_W]),
        .b_i(b_q[cnt_q*CHUNK_W +: CHUNK_W]),
        .c_i(carry_q),
        .s_o(chunk_s),
        .c_o(chunk_c)
    );

    // Next-state: capture operands on an accepted rise, ripple one chunk per CALC cycle, publish in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sgn_d   = sgn_q;
        sub_d   = sub_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: if (rise) begin
                a_d     = bus.augend;
                b_d     = bus.control[CTRL_SUB] ? ~bus.addend : bus.addend;
                carry_d = bus.control[CTRL_SUB];
                sgn_d   = bus.control[CTRL_SIGNED];
                sub_d   = bus.control[CTRL_SUB];
                cnt_d   = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                r_d[cnt_q*CHUNK_W +: CHUNK_W] = chunk_s;
                carry_d = chunk_c;
                cnt_d   = cnt_q == CNT_W'(N - 1) ? '0 : cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(N - 1) ? ST_DONE : ST_CALC;
            end
            ST_DONE: begin
                sum_d   = r_q;
                ovf_d   = sgn_q ? (a_q[MSB] == b_q[MSB]) & (r_q[MSB] != a_q[MSB]) : carry_q ^ sub_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight and clears all results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sgn_q   <= 1'b0;
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sgn_q   <= sgn_d;
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= bus.control[CTRL_START];
        end
    end

    assign bus.sum      = sum_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
